// File: rtl/mips32_pipe.sv
// mips32_pipe: 5-stage MIPS32 core with internal word-addressed I/D memories, interlocks and optional forwarding.
// Latency: fetch to writeback is 5 edges. ID stalls on RAW hazards. A taken branch flushes 2 slots.
module mips32_pipe #(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 512,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16,
  localparam int PC_W      = $clog2(IMEM_DEPTH),
  localparam int DA_W      = $clog2(DMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_wdata,
  input  logic              dmem_we_ext,
  input  logic [DA_W-1:0]   dmem_addr_ext,
  input  logic [DATA_W-1:0] dmem_wdata_ext,
  output logic [DATA_W-1:0] dmem_rdata_ext,
  input  logic [4:0]        dbg_reg_addr,
  output logic [DATA_W-1:0] dbg_reg_data,
  output logic              halted,
  output logic [CNT_W-1:0]  retired,
  output logic [CNT_W-1:0]  stalls
);
  localparam logic [5:0] OP_ADD   = 6'h00, OP_SUB   = 6'h01, OP_AND  = 6'h02, OP_OR   = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04, OP_MUL   = 6'h05, OP_LW   = 6'h08, OP_SW   = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0A, OP_SUBI  = 6'h0B, OP_SLTI = 6'h0C;
  localparam logic [5:0] OP_BNEQZ = 6'h0D, OP_BEQZ  = 6'h0E, OP_HLT  = 6'h3F;
  localparam logic FWD = (FWD_EN != 0);

  logic [31:0]       imem_q [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];
  logic [DATA_W-1:0] rf_q   [32];

  logic [PC_W-1:0]   pc_q, pc_d;
  logic              hlt_seen_q, halted_q;
  logic [CNT_W-1:0]  retired_q, stalls_q;

  logic              ifid_vld_q;
  logic [31:0]       ifid_ir_q;
  logic [PC_W-1:0]   ifid_pc_q;

  logic              idex_vld_q;
  logic [5:0]        idex_op_q;
  logic [4:0]        idex_rs_q, idex_rt_q, idex_dst_q;
  logic [DATA_W-1:0] idex_a_q, idex_b_q, idex_imm_q;
  logic [PC_W-1:0]   idex_pc_q;

  logic              exmem_vld_q;
  logic [5:0]        exmem_op_q;
  logic [4:0]        exmem_dst_q;
  logic [DATA_W-1:0] exmem_res_q, exmem_sdat_q;

  logic              memwb_vld_q;
  logic [5:0]        memwb_op_q;
  logic [4:0]        memwb_dst_q;
  logic [DATA_W-1:0] memwb_res_q;

  // ---------------- ID: decode, register read, hazard detection
  logic [5:0]        id_op;
  logic [4:0]        id_rs, id_rt, id_rd, id_dst;
  logic [DATA_W-1:0] id_imm, id_a, id_b;
  logic              id_uses_rs, id_uses_rt, id_is_hlt;
  logic              wb_we;

  assign id_op  = ifid_ir_q[31:26];
  assign id_rs  = ifid_ir_q[25:21];
  assign id_rt  = ifid_ir_q[20:16];
  assign id_rd  = ifid_ir_q[15:11];
  assign id_imm = {{(DATA_W-16){ifid_ir_q[15]}}, ifid_ir_q[15:0]};

  always_comb begin
    id_uses_rs = 1'b0;
    id_uses_rt = 1'b0;
    id_dst     = 5'd0;
    id_is_hlt  = ifid_vld_q && (id_op == OP_HLT);
    if (ifid_vld_q) begin
      case (id_op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
          id_uses_rs = 1'b1;
          id_uses_rt = 1'b1;
          id_dst     = id_rd;
        end
        OP_LW, OP_ADDI, OP_SUBI, OP_SLTI: begin
          id_uses_rs = 1'b1;
          id_dst     = id_rt;
        end
        OP_SW: begin
          id_uses_rs = 1'b1;
          id_uses_rt = 1'b1;
        end
        OP_BNEQZ, OP_BEQZ: id_uses_rs = 1'b1;
        default: ;
      endcase
    end
  end

  // Write-through: a same-cycle WB write is visible to the ID read.
  assign wb_we = memwb_vld_q && !halted_q && (memwb_dst_q != 5'd0);
  assign id_a  = (id_rs == 5'd0) ? '0 : (wb_we && memwb_dst_q == id_rs) ? memwb_res_q : rf_q[id_rs];
  assign id_b  = (id_rt == 5'd0) ? '0 : (wb_we && memwb_dst_q == id_rt) ? memwb_res_q : rf_q[id_rt];

  logic ex_dep, mem_dep, hazard, stall, flush, fetch_stop;

  assign ex_dep  = idex_vld_q && (idex_dst_q != 5'd0) &&
                   ((id_uses_rs && idex_dst_q == id_rs) || (id_uses_rt && idex_dst_q == id_rt));
  assign mem_dep = exmem_vld_q && (exmem_dst_q != 5'd0) &&
                   ((id_uses_rs && exmem_dst_q == id_rs) || (id_uses_rt && exmem_dst_q == id_rt));
  assign hazard  = FWD ? (ex_dep && idex_op_q == OP_LW) : (ex_dep || mem_dep);
  assign stall   = hazard && !flush;
  // Once HLT has reached ID nothing younger may enter the pipe.
  assign fetch_stop = id_is_hlt || hlt_seen_q;

  // ---------------- EX: operand forwarding, ALU, branch resolution
  logic              fwd_m_a, fwd_w_a, fwd_m_b, fwd_w_b;
  logic [DATA_W-1:0] ex_a, ex_b, ex_res;
  logic              ex_taken;
  logic [PC_W-1:0]   ex_target;

  assign fwd_m_a = FWD && exmem_vld_q && exmem_op_q != OP_LW && exmem_dst_q != 5'd0 && exmem_dst_q == idex_rs_q;
  assign fwd_w_a = FWD && memwb_vld_q && memwb_dst_q != 5'd0 && memwb_dst_q == idex_rs_q;
  assign fwd_m_b = FWD && exmem_vld_q && exmem_op_q != OP_LW && exmem_dst_q != 5'd0 && exmem_dst_q == idex_rt_q;
  assign fwd_w_b = FWD && memwb_vld_q && memwb_dst_q != 5'd0 && memwb_dst_q == idex_rt_q;

  assign ex_a = fwd_m_a ? exmem_res_q : fwd_w_a ? memwb_res_q : idex_a_q;
  assign ex_b = fwd_m_b ? exmem_res_q : fwd_w_b ? memwb_res_q : idex_b_q;

  always_comb begin
    ex_res = '0;
    case (idex_op_q)
      OP_ADD:         ex_res = ex_a + ex_b;
      OP_SUB:         ex_res = ex_a - ex_b;
      OP_AND:         ex_res = ex_a & ex_b;
      OP_OR:          ex_res = ex_a | ex_b;
      OP_SLT:         ex_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
      OP_MUL:         ex_res = ex_a * ex_b;
      OP_LW, OP_SW,
      OP_ADDI:        ex_res = ex_a + idex_imm_q;
      OP_SUBI:        ex_res = ex_a - idex_imm_q;
      OP_SLTI:        ex_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(idex_imm_q))};
      default:        ex_res = '0;
    endcase
  end

  assign ex_taken  = idex_vld_q && ((idex_op_q == OP_BNEQZ && ex_a != '0) ||
                                    (idex_op_q == OP_BEQZ  && ex_a == '0));
  assign ex_target = idex_pc_q + PC_W'(1) + idex_imm_q[PC_W-1:0];
  assign flush     = ex_taken;

  // ---------------- MEM
  logic [DATA_W-1:0] mem_res;
  assign mem_res = (exmem_op_q == OP_LW) ? dmem_q[exmem_res_q[DA_W-1:0]] : exmem_res_q;

  // ---------------- next-state for PC and counters
  logic [CNT_W-1:0] retired_d, stalls_d;
  assign pc_d      = flush ? ex_target : (stall || fetch_stop) ? pc_q : pc_q + PC_W'(1);
  assign retired_d = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);
  assign stalls_d  = (stalls_q  == '1) ? stalls_q  : stalls_q  + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      hlt_seen_q  <= 1'b0;
      halted_q    <= 1'b0;
      retired_q   <= '0;
      stalls_q    <= '0;
      ifid_vld_q  <= 1'b0;
      idex_vld_q  <= 1'b0;
      exmem_vld_q <= 1'b0;
      memwb_vld_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;

      if (flush || (!stall && fetch_stop)) begin
        ifid_vld_q <= 1'b0;
      end else if (!stall) begin
        ifid_vld_q <= 1'b1;
        ifid_ir_q  <= imem_q[pc_q];
        ifid_pc_q  <= pc_q;
      end

      idex_vld_q <= ifid_vld_q && !flush && !stall;
      idex_op_q  <= id_op;
      idex_rs_q  <= id_rs;
      idex_rt_q  <= id_rt;
      idex_dst_q <= id_dst;
      idex_a_q   <= id_a;
      idex_b_q   <= id_b;
      idex_imm_q <= id_imm;
      idex_pc_q  <= ifid_pc_q;
      if (id_is_hlt && !flush) hlt_seen_q <= 1'b1;

      exmem_vld_q  <= idex_vld_q;
      exmem_op_q   <= idex_op_q;
      exmem_dst_q  <= idex_dst_q;
      exmem_res_q  <= ex_res;
      exmem_sdat_q <= ex_b;

      memwb_vld_q <= exmem_vld_q;
      memwb_op_q  <= exmem_op_q;
      memwb_dst_q <= exmem_dst_q;
      memwb_res_q <= mem_res;

      if (memwb_vld_q && !halted_q) begin
        if (wb_we) rf_q[memwb_dst_q] <= memwb_res_q;
        retired_q <= retired_d;
        if (memwb_op_q == OP_HLT) halted_q <= 1'b1;
      end
      if (stall && !halted_q) stalls_q <= stalls_d;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_we) imem_q[imem_addr] <= imem_wdata;
  end

  // The external port wins a same-edge collision with a store.
  always_ff @(posedge clk) begin
    if (dmem_we_ext)
      dmem_q[dmem_addr_ext] <= dmem_wdata_ext;
    else if (!rst && !halted_q && exmem_vld_q && exmem_op_q == OP_SW)
      dmem_q[exmem_res_q[DA_W-1:0]] <= exmem_sdat_q;
  end

  assign dmem_rdata_ext = dmem_q[dmem_addr_ext];
  assign dbg_reg_data   = rf_q[dbg_reg_addr];
  assign halted         = halted_q;
  assign retired        = retired_q;
  assign stalls         = stalls_q;

endmodule

// File: tb/tb_mips32_pipe.sv
// Bench for mips32_pipe: a forwarding and a stall-only instance run the same directed programs side by side.
module tb_mips32_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_addr = '0;
  logic [31:0] imem_wdata = '0;
  logic        dmem_we_ext = 1'b0;
  logic [8:0]  dmem_addr_ext = '0;
  logic [31:0] dmem_wdata_ext = '0;
  logic [4:0]  dbg_reg_addr = '0;

  logic [31:0] drd_d     [2];
  logic [31:0] dbg_d     [2];
  logic        halted_d  [2];
  logic [15:0] retired_d [2];
  logic [15:0] stalls_d  [2];

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] FACT [8] = '{32'h280A00C8, 32'h28020001, 32'h21430000, 32'h14431000,
                                       32'h2C630001, 32'h3460FFFD, 32'h2542FFFE, 32'hFC000000};

  always #5 clk = ~clk;

  mips32_pipe #(.FWD_EN(1)) u_fwd (
    .clk(clk), .rst(rst), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we_ext(dmem_we_ext), .dmem_addr_ext(dmem_addr_ext), .dmem_wdata_ext(dmem_wdata_ext),
    .dmem_rdata_ext(drd_d[0]), .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_d[0]),
    .halted(halted_d[0]), .retired(retired_d[0]), .stalls(stalls_d[0]));

  mips32_pipe #(.FWD_EN(0)) u_nofwd (
    .clk(clk), .rst(rst), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we_ext(dmem_we_ext), .dmem_addr_ext(dmem_addr_ext), .dmem_wdata_ext(dmem_wdata_ext),
    .dmem_rdata_ext(drd_d[1]), .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_d[1]),
    .halted(halted_d[1]), .retired(retired_d[1]), .stalls(stalls_d[1]));

  task automatic begin_load();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic imem_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    imem_we = 1'b1; imem_addr = a; imem_wdata = d;
    @(posedge clk);
    #1 imem_we = 1'b0;
  endtask

  task automatic dmem_wr(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    dmem_we_ext = 1'b1; dmem_addr_ext = a; dmem_wdata_ext = d;
    @(posedge clk);
    #1 dmem_we_ext = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (halted_d[0] && halted_d[1]) ok = 1'b1;
    end
  endtask

  task automatic sel_reg(input logic [4:0] r);
    @(negedge clk);
    dbg_reg_addr = r;
    #1;
  endtask

  task automatic test_reset();
    begin_load();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (halted_d[k] !== 1'b0) begin errors++; $display("FAIL reset_halted[%0d]: got %b want 0", k, halted_d[k]); end
      checks++;
      if (retired_d[k] !== 16'd0) begin errors++; $display("FAIL reset_retired[%0d]: got %0d want 0", k, retired_d[k]); end
      checks++;
      if (stalls_d[k] !== 16'd0) begin errors++; $display("FAIL reset_stalls[%0d]: got %0d want 0", k, stalls_d[k]); end
    end
    sel_reg(5'd5);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dbg_d[k] !== 32'd0) begin errors++; $display("FAIL reset_r5[%0d]: got %0d want 0", k, dbg_d[k]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    begin_load();
    imem_wr(8'd0, 32'h28010007);
    imem_wr(8'd1, 32'h00211000);
    imem_wr(8'd2, 32'h04411800);
    imem_wr(8'd3, 32'hFC000000);
    dbg_reg_addr = 5'd1;
    release_rst();
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dbg_d[0] !== 32'd0) begin errors++; $display("FAIL latency_pre_e4: got %0d want 0", dbg_d[0]); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (dbg_d[0] !== 32'd7) begin errors++; $display("FAIL latency_post_e4: got %0d want 7", dbg_d[0]); end
    wait_halt(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_halt: halted=%b%b want 11", halted_d[0], halted_d[1]); end
    sel_reg(5'd2);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dbg_d[k] !== 32'd14) begin errors++; $display("FAIL b2b_r2[%0d]: got %0d want 14", k, dbg_d[k]); end
    end
    sel_reg(5'd3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dbg_d[k] !== 32'd7) begin errors++; $display("FAIL b2b_r3[%0d]: got %0d want 7", k, dbg_d[k]); end
      checks++;
      if (retired_d[k] !== 16'd4) begin errors++; $display("FAIL b2b_retired[%0d]: got %0d want 4", k, retired_d[k]); end
    end
    checks++;
    if (stalls_d[0] !== 16'd0) begin errors++; $display("FAIL b2b_stalls_fwd: got %0d want 0", stalls_d[0]); end
    checks++;
    if (stalls_d[1] !== 16'd4) begin errors++; $display("FAIL b2b_stalls_nofwd: got %0d want 4", stalls_d[1]); end
  endtask

  task automatic test_branch_flush();
    bit ok;
    begin_load();
    imem_wr(8'd0, 32'h38000002);
    imem_wr(8'd1, 32'h28050009);
    imem_wr(8'd2, 32'h28060009);
    imem_wr(8'd3, 32'h28070003);
    imem_wr(8'd4, 32'hFC000000);
    release_rst();
    wait_halt(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL br_halt: halted=%b%b want 11", halted_d[0], halted_d[1]); end
    sel_reg(5'd5);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dbg_d[k] !== 32'd0) begin errors++; $display("FAIL br_r5[%0d]: got %0d want 0", k, dbg_d[k]); end
    end
    sel_reg(5'd6);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dbg_d[k] !== 32'd0) begin errors++; $display("FAIL br_r6[%0d]: got %0d want 0", k, dbg_d[k]); end
    end
    sel_reg(5'd7);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dbg_d[k] !== 32'd3) begin errors++; $display("FAIL br_r7[%0d]: got %0d want 3", k, dbg_d[k]); end
      checks++;
      if (retired_d[k] !== 16'd3) begin errors++; $display("FAIL br_retired[%0d]: got %0d want 3", k, retired_d[k]); end
    end
  endtask

  task automatic test_wrap_r0();
    bit ok;
    begin_load();
    imem_wr(8'd0, 32'h28000005);
    imem_wr(8'd1, 32'h2801FFFF);
    imem_wr(8'd2, 32'h28210001);
    imem_wr(8'd3, 32'hFC000000);
    release_rst();
    wait_halt(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_halt: halted=%b%b want 11", halted_d[0], halted_d[1]); end
    sel_reg(5'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dbg_d[k] !== 32'd0) begin errors++; $display("FAIL wrap_r0[%0d]: got %0d want 0", k, dbg_d[k]); end
    end
    sel_reg(5'd1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dbg_d[k] !== 32'd0) begin errors++; $display("FAIL wrap_r1[%0d]: got %h want 0", k, dbg_d[k]); end
    end
  endtask

  task automatic load_factorial();
    begin_load();
    for (int i = 0; i < 8; i++) imem_wr(8'(i), FACT[i]);
    dmem_wr(9'd198, 32'd0);
    dmem_wr(9'd200, 32'd5);
    dmem_addr_ext = 9'd198;
  endtask

  task automatic test_factorial();
    bit ok;
    load_factorial();
    release_rst();
    wait_halt(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fact_halt: halted=%b%b want 11", halted_d[0], halted_d[1]); end
    sel_reg(5'd2);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dbg_d[k] !== 32'd120) begin errors++; $display("FAIL fact_r2[%0d]: got %0d want 120", k, dbg_d[k]); end
      checks++;
      if (drd_d[k] !== 32'd120) begin errors++; $display("FAIL fact_mem198[%0d]: got %0d want 120", k, drd_d[k]); end
      checks++;
      if (retired_d[k] !== 16'd20) begin errors++; $display("FAIL fact_retired[%0d]: got %0d want 20", k, retired_d[k]); end
    end
    sel_reg(5'd3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dbg_d[k] !== 32'd0) begin errors++; $display("FAIL fact_r3[%0d]: got %0d want 0", k, dbg_d[k]); end
    end
    sel_reg(5'd10);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dbg_d[k] !== 32'd200) begin errors++; $display("FAIL fact_r10[%0d]: got %0d want 200", k, dbg_d[k]); end
    end
    checks++;
    if (stalls_d[0] !== 16'd1) begin errors++; $display("FAIL fact_stalls_fwd: got %0d want 1", stalls_d[0]); end
    checks++;
    if (!(stalls_d[1] > stalls_d[0])) begin
      errors++; $display("FAIL fact_stalls_nofwd: got %0d want more than %0d", stalls_d[1], stalls_d[0]);
    end
  endtask

  task automatic test_reset_mid_loop();
    bit ok;
    load_factorial();
    release_rst();
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (retired_d[k] !== 16'd0) begin errors++; $display("FAIL mid_retired[%0d]: got %0d want 0", k, retired_d[k]); end
      checks++;
      if (stalls_d[k] !== 16'd0) begin errors++; $display("FAIL mid_stalls[%0d]: got %0d want 0", k, stalls_d[k]); end
      checks++;
      if (drd_d[k] !== 32'd0) begin errors++; $display("FAIL mid_mem198[%0d]: got %0d want 0", k, drd_d[k]); end
    end
    for (int r = 2; r <= 10; r += 8) begin
      dbg_reg_addr = 5'(r);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dbg_d[k] !== 32'd0) begin errors++; $display("FAIL mid_r%0d[%0d]: got %0d want 0", r, k, dbg_d[k]); end
      end
    end
    rst = 1'b0;
    wait_halt(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_halt: halted=%b%b want 11", halted_d[0], halted_d[1]); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (drd_d[k] !== 32'd120) begin errors++; $display("FAIL mid_rerun_mem198[%0d]: got %0d want 120", k, drd_d[k]); end
      checks++;
      if (retired_d[k] !== 16'd20) begin errors++; $display("FAIL mid_rerun_retired[%0d]: got %0d want 20", k, retired_d[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_branch_flush();
    test_wrap_r0();
    test_factorial();
    test_reset_mid_loop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
